// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath: register numbers and
// widths used by the register file, the write-register select mux and control.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd28;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

endpackage : mips_pkg

// File: rtl/register_file_rf_read_port.sv
// One combinational read port of the register file. Applies the r0-reads-zero
// rule and, when BYPASS is set, forwards the in-flight write data.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic                           rst_n_i,
  input  logic [REG_ADDR_W-1:0]          idx_i,
  input  logic [NUM_REGS-1:0][WIDTH-1:0] regs_i,
  input  logic                           wr_en_i,
  input  logic [REG_ADDR_W-1:0]          wr_idx_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  output logic [WIDTH-1:0]               data_o
);

  logic fwd_hit;

  // Forwarding only applies to a write that would actually commit, and never
  // while reset is held, so reads during reset always show reset values.
  assign fwd_hit = BYPASS && rst_n_i && wr_en_i &&
                   (wr_idx_i != REG_ZERO) && (idx_i == wr_idx_i);

  // Select stored value, override with forwarded data, then force r0 to zero.
  always_comb begin
    data_o = regs_i[idx_i];
    if (fwd_hit) begin
      data_o = wr_data_i;
    end
    if (idx_i == REG_ZERO) begin
      data_o = '0;
    end
  end

endmodule : rf_read_port

// File: rtl/register_file.sv
// Architectural register file: 31 stored registers (r1..r31), two operand read
// ports, one debug read port that never forwards, and a committed-write counter.
module register_file
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SP_RESET = 32'h0000_3FFC,
  parameter logic [WIDTH-1:0] GP_RESET = 32'h0000_1800,
  parameter bit               BYPASS   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  input  logic [REG_ADDR_W-1:0] DbgReg,
  output logic [WIDTH-1:0]      DbgData,
  output logic [31:0]           WriteCount
);

  logic [WIDTH-1:0]               regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_bus;
  logic [31:0]                    count_q;
  logic [31:0]                    count_d;
  logic                           commit;

  // A write to r0 is dropped entirely: no storage update, no count.
  assign commit  = RegWrite && (WriteReg != REG_ZERO);
  assign count_d = count_q + 32'd1;

  // Flatten storage into a full 32-entry bus; entry 0 is a constant zero.
  always_comb begin
    regs_bus[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_bus[i] = regs_q[i];
    end
  end

  // Storage and write counter; async reset loads $gp/$sp and clears the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i == int'(REG_GP)) begin
          regs_q[i] <= GP_RESET;
        end else if (i == int'(REG_SP)) begin
          regs_q[i] <= SP_RESET;
        end else begin
          regs_q[i] <= '0;
        end
      end
      count_q <= '0;
    end else if (commit) begin
      regs_q[WriteReg] <= WriteData;
      count_q          <= count_d;
    end
  end

  assign WriteCount = count_q;

  rf_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rd1 (
    .rst_n_i   (rst_n),
    .idx_i     (ReadReg1),
    .regs_i    (regs_bus),
    .wr_en_i   (RegWrite),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .data_o    (ReadData1)
  );

  rf_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rd2 (
    .rst_n_i   (rst_n),
    .idx_i     (ReadReg2),
    .regs_i    (regs_bus),
    .wr_en_i   (RegWrite),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .data_o    (ReadData2)
  );

  // Debug port always shows committed state, even with forwarding enabled.
  rf_read_port #(.WIDTH(WIDTH), .BYPASS(1'b0)) u_dbg (
    .rst_n_i   (rst_n),
    .idx_i     (DbgReg),
    .regs_i    (regs_bus),
    .wr_en_i   (RegWrite),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .data_o    (DbgData)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: one instance without forwarding and one with,
// driven by shared stimulus and checked against a reference model via a queue.
module tb_register_file;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wr = '0, r1 = '0, r2 = '0, dbg = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd1_0, rd2_0, dbg_0, cnt_0;
  logic [31:0] rd1_1, rd2_1, dbg_1, cnt_1;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wr), .WriteData(wd),
    .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_0), .ReadData2(rd2_0),
    .DbgReg(dbg), .DbgData(dbg_0), .WriteCount(cnt_0)
  );

  register_file #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wr), .WriteData(wd),
    .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_1), .ReadData2(rd2_1),
    .DbgReg(dbg), .DbgData(dbg_1), .WriteCount(cnt_1)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reset_val(input int idx);
    if (idx == 28) return 32'h0000_1800;
    if (idx == 29) return 32'h0000_3FFC;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = reset_val(i);
    m_cnt = 32'h0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && rst_n && we && (wr != 5'd0) && (idx == wr)) return wd;
    return m_regs[idx];
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_expect();
    push("d0.rd1", m_read(r1, 1'b0));
    push("d0.rd2", m_read(r2, 1'b0));
    push("d0.dbg", m_read(dbg, 1'b0));
    push("d0.cnt", m_cnt);
    push("d1.rd1", m_read(r1, 1'b1));
    push("d1.rd2", m_read(r2, 1'b1));
    push("d1.dbg", m_read(dbg, 1'b0));
    push("d1.cnt", m_cnt);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got %h expected none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic compare_outputs();
    sb_pop(rd1_0); sb_pop(rd2_0); sb_pop(dbg_0); sb_pop(cnt_0);
    sb_pop(rd1_1); sb_pop(rd2_1); sb_pop(dbg_1); sb_pop(cnt_1);
  endtask

  task automatic settle();
    push_expect();
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic a_we, input logic [4:0] a_wr, input logic [31:0] a_wd,
                       input logic [4:0] a_r1, input logic [4:0] a_r2, input logic [4:0] a_dbg);
    we = a_we; wr = a_wr; wd = a_wd; r1 = a_r1; r2 = a_r2; dbg = a_dbg;
    settle();
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && we && (wr != 5'd0)) begin
      m_regs[wr] = wd;
      m_cnt      = m_cnt + 32'd1;
    end
    #1;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset pulse mid-cycle and sweep of the debug port.
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      dbg = 5'(i);
      settle();
      check($sformatf("rst_dbg_r%0d", i), dbg_0, reset_val(i));
    end
    check("rst_cnt", cnt_1, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    settle();

    // Basic write/read of r8.
    @(negedge clk);
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0, 5'd8);
    check("pre_edge_nobyp_r8", rd1_0, 32'h0);
    check("pre_edge_byp_r8", rd1_1, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd0, 5'd8);
    check("post_edge_r8", rd1_0, 32'hDEAD_BEEF);
    check("cnt_after_r8", cnt_0, 32'd1);

    // r0 protection.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check("r0_pre_byp", rd2_1, 32'h0);
    step();
    check("r0_post_byp", rd2_1, 32'h0);
    check("r0_cnt", cnt_1, 32'd1);

    // Same-cycle read/write of r9; the two writes are back to back.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'd5, 5'd0, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd9, 32'd7, 5'd9, 5'd9, 5'd9);
    check("rw_nobyp_p1", rd1_0, 32'd5);
    check("rw_nobyp_p2", rd2_0, 32'd5);
    check("rw_byp_p1", rd1_1, 32'd7);
    check("rw_byp_p2", rd2_1, 32'd7);
    check("rw_dbg_old", dbg_1, 32'd5);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    check("rw_post_p1", rd1_0, 32'd7);
    check("rw_post_p2", rd2_0, 32'd7);
    check("rw_cnt", cnt_0, 32'd3);

    // Reset arriving before the edge of an in-flight write.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'd3, 5'd0, 5'd0, 5'd0);
    step();
    @(negedge clk);
    drive(1'b1, 5'd10, 32'd9, 5'd10, 5'd29, 5'd10);
    check("pre_rst_byp", rd1_1, 32'd9);
    rst_n = 1'b0;
    model_reset();
    settle();
    check("rst_byp_suppressed", rd1_1, 32'h0);
    check("rst_sp_read", rd2_1, 32'h0000_3FFC);
    step();
    @(negedge clk);
    we = 1'b0;
    #1;
    rst_n = 1'b1;
    settle();
    check("rst_lost_write", dbg_0, 32'h0);
    check("rst_lost_cnt", cnt_0, 32'h0);
    drive(1'b1, 5'd10, 32'd4, 5'd10, 5'd0, 5'd10);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 5'd10);
    check("post_rel_r10", rd1_0, 32'd4);
    check("post_rel_cnt", cnt_0, 32'd1);

    // Randomised traffic checked against the model.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
    end

    // Counter wrap via backdoor.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
    force dut0.count_q = 32'hFFFF_FFFF;
    force dut1.count_q = 32'hFFFF_FFFF;
    #1;
    release dut0.count_q;
    release dut1.count_q;
    m_cnt = 32'hFFFF_FFFF;
    settle();
    drive(1'b1, 5'd5, 32'h0000_0123, 5'd5, 5'd0, 5'd5);
    step();
    check("wrap_cnt0", cnt_0, 32'h0);
    check("wrap_cnt1", cnt_1, 32'h0);
    check("wrap_reg", dbg_0, 32'h0000_0123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_register_file
